// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, one result consumer and the shared ALU.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [1:0]       i_op0;
  logic [1:0]       i_op1;
  logic [WIDTH-1:0] i_a0;
  logic [WIDTH-1:0] i_b0;
  logic [WIDTH-1:0] i_a1;
  logic [WIDTH-1:0] i_b1;
  logic             o_rsp_valid;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_data;
  logic             i_rsp_ready;

  modport master (
    output i_req_valid, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
  );

  modport slave (
    input  i_req_valid, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single plus/minus/mul datapath.
// One operation in flight; result held in DONE until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]       grant_c;
  logic             accept_c;
  logic             sel_c;
  logic [1:0]       op_sel_c;
  logic [WIDTH-1:0] result_c;

  // Grant is only offered in IDLE; ties broken by the round-robin pointer.
  always_comb begin
    grant_c = 2'b00;
    if (!i_rst && state_q == IDLE) begin
      case (bus.i_req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_q ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign accept_c = |(bus.i_req_valid & grant_c);
  assign sel_c    = grant_c[1];
  assign op_sel_c = sel_c ? bus.i_op1 : bus.i_op0;

  // Shared datapath; low WIDTH bits are identical for signed and unsigned operands.
  always_comb begin
    result_c = '0;
    case (op_q)
      2'b00:   result_c = a_q + b_q;
      2'b01:   result_c = a_q - b_q;
      2'b10:   result_c = a_q * b_q;
      default: result_c = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d  = EXEC;
          op_d     = op_sel_c;
          a_d      = sel_c ? bus.i_a1 : bus.i_a0;
          b_d      = sel_c ? bus.i_b1 : bus.i_b0;
          rsp_id_d = sel_c;
          cnt_d    = (op_sel_c == 2'b10) ? CNT_W'(MUL_LAT - 1) : '0;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = result_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rr_d        = ~rsp_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.o_req_ready = grant_c;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_data_q;

endmodule
